// File: rtl/alu_share_ctrl.sv
//-----------------------------------------------------------------------------
// alu_share_ctrl
//   Two-requester round-robin arbiter and sequencer for a shared 4-bit ALU.
//   Accepts one operation at a time, holds the ALU inputs for SETTLE cycles,
//   captures the result and returns it through a held response handshake.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid[1:0]             per-requester request
//   req_op0/1, req_a0/1, req_b0/1  select and operands from requester 0/1
//   req_ready[1:0]             one-hot accept (combinational, IDLE only)
//   rsp_valid[1:0]             one-hot response valid to the owner
//   rsp_ready[1:0]             per-requester response accept
//   rsp_y, rsp_z               captured ALU result / flag
//   alu_a, alu_b, alu_c1, alu_c0   registered ALU inputs
//   alu_y, alu_z               ALU result / flag
//   busy                       high while an operation is in flight
//
// Revision: 1.0 initial release
//-----------------------------------------------------------------------------
`default_nettype none

module alu_share_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_op0,
  input  logic [1:0] req_op1,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b0,
  input  logic [3:0] req_b1,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_y,
  output logic       rsp_z,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_c1,
  output logic       alu_c0,
  input  logic [3:0] alu_y,
  input  logic       alu_z,
  output logic       busy
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t     state_q;
  logic       owner_q;
  logic       ptr_q;
  logic [3:0] cnt_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] op_q;
  logic [3:0] y_q;
  logic       z_q;
  logic [1:0] rsp_valid_q;
  logic       busy_q;

  // Arbitration: a lone requester wins; on contention the pointer decides.
  logic       win_d;
  logic [1:0] gnt_d;

  always_comb begin
    win_d = (req_valid == 2'b10) || ((req_valid == 2'b11) && ptr_q);
    gnt_d = 2'b00;
    if (req_valid != 2'b00) begin
      gnt_d = win_d ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = (state_q == S_IDLE) ? gnt_d : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      op_q        <= 2'b00;
      y_q         <= 4'd0;
      z_q         <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid != 2'b00) begin
            a_q     <= win_d ? req_a1 : req_a0;
            b_q     <= win_d ? req_b1 : req_b0;
            op_q    <= win_d ? req_op1 : req_op0;
            owner_q <= win_d;
            ptr_q   <= ~win_d;
            cnt_q   <= SETTLE_CNT;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q - 4'd1;
          // Last settle edge: the ALU has had SETTLE cycles on stable inputs.
          if (cnt_q == 4'd1) begin
            y_q         <= alu_y;
            z_q         <= alu_z;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          // Only the owner's ready completes the response.
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = y_q;
  assign rsp_z     = z_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_c1    = op_q[1];
  assign alu_c0    = op_q[0];
  assign busy      = busy_q;

endmodule

`default_nettype wire
